// File: rtl/ft_clk_mon.sv
// ft_clk_mon: measures activity of a divided-down FT-domain clock from the
// system clock domain. The monitor counts transitions per fixed window,
// debounces a clock-OK flag over several good windows and keeps a sticky
// clock-lost flag for the status LED stage.
module ft_clk_mon #(
    parameter int WIN_CYC   = 5_000_000,
    parameter int CNT_W     = 24,
    parameter int MIN_EDGES = 40_000,
    parameter int MAX_EDGES = 54_000,
    parameter int GOOD_WIN  = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ft_div_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_vld_o,
    output logic             clk_ok_o,
    output logic             lost_o
);

    // The window counter only needs to reach WIN_CYC-1.
    localparam int WIN_W = $clog2(WIN_CYC);
    // The run counter must be able to hold GOOD_WIN itself.
    localparam int RUN_W = $clog2(GOOD_WIN + 1);
    // The range check runs at a width that holds both the count and the limits,
    // so limits above the counter range never wrap.
    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_TGT  = RUN_W'(GOOD_WIN);
    localparam logic [CMP_W-1:0] MIN_U    = CMP_W'(MIN_EDGES);
    localparam logic [CMP_W-1:0] MAX_U    = CMP_W'(MAX_EDGES);

    typedef enum logic [1:0] {
        ST_LOST  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OK    = 2'd2
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_ec;
    logic [RUN_W-1:0] r_run;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vld;
    logic             r_clkOk;
    logic             r_lost;

    logic             w_edge;
    logic             w_winEnd;
    logic [CNT_W-1:0] w_ecNext;
    logic [CMP_W-1:0] w_cntExt;
    logic             w_good;
    state_t           w_stateNxt;
    logic [RUN_W-1:0] w_runNxt;
    logic             w_setLost;

    // Either polarity of transition on the synchronized input counts as an edge.
    assign w_edge   = r_s2 ^ r_s3;
    assign w_winEnd = (r_win == WIN_LAST);
    assign w_ecNext = (w_edge && (r_ec != CNT_MAX)) ? (r_ec + CNT_W'(1)) : r_ec;
    assign w_cntExt = CMP_W'(w_ecNext);
    assign w_good   = (w_cntExt >= MIN_U) && (w_cntExt <= MAX_U);

    // Two-flop synchronizer for the asynchronous FT input plus an edge-detect stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ft_div_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Window timer and saturating edge counter; the counter restarts each window
    // so every edge lands in exactly one reported count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_win <= '0;
            r_ec  <= '0;
        end else if (w_winEnd) begin
            r_win <= '0;
            r_ec  <= '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
            r_ec  <= w_ecNext;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_LOST;
            r_run   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_run   <= w_runNxt;
        end
    end

    // Next-state logic, evaluated only on the window-end cycle.
    always_comb begin
        w_stateNxt = r_state;
        w_runNxt   = r_run;
        w_setLost  = 1'b0;
        if (w_winEnd) begin
            case (r_state)
                ST_LOST: begin
                    if (w_good) begin
                        w_runNxt   = RUN_W'(1);
                        w_stateNxt = (GOOD_WIN == 1) ? ST_OK : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_good) begin
                        w_runNxt = r_run + RUN_W'(1);
                        if ((r_run + RUN_W'(1)) == RUN_TGT) begin
                            w_stateNxt = ST_OK;
                        end
                    end else begin
                        w_runNxt   = '0;
                        w_stateNxt = ST_LOST;
                    end
                end
                ST_OK: begin
                    if (!w_good) begin
                        w_runNxt   = '0;
                        w_stateNxt = ST_LOST;
                        w_setLost  = 1'b1;
                    end
                end
                default: begin
                    w_runNxt   = '0;
                    w_stateNxt = ST_LOST;
                end
            endcase
        end
    end

    // Registered outputs: count, valid strobe and OK flag all move on the window-end edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_clkOk <= 1'b0;
        end else begin
            r_vld <= w_winEnd;
            if (w_winEnd) begin
                r_cnt   <= w_ecNext;
                r_clkOk <= (w_stateNxt == ST_OK);
            end
        end
    end

    // Sticky lost flag; a new loss takes priority over a coincident clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lost <= 1'b0;
        end else if (w_setLost) begin
            r_lost <= 1'b1;
        end else if (clr_i) begin
            r_lost <= 1'b0;
        end
    end

    assign cnt_o     = r_cnt;
    assign cnt_vld_o = r_vld;
    assign clk_ok_o  = r_clkOk;
    assign lost_o    = r_lost;

endmodule

// File: tb/tb_ft_clk_mon.sv
// tb_ft_clk_mon: directed bench for ft_clk_mon with a 100-cycle window.
// A second instance with a 4-bit counter covers count saturation.
module tb_ft_clk_mon;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ftDiv;
    logic       clr;
    logic [7:0] cnt;
    logic       vld;
    logic       ok;
    logic       lost;
    logic [3:0] cntS;
    logic       vldS;
    logic       okS;
    logic       lostS;

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   phase   = 0;
    int   halfPer = 10;
    bit   ftRun   = 1'b0;
    logic prevOk  = 1'b0;
    logic prevLost = 1'b0;

    ft_clk_mon #(
        .WIN_CYC(100), .CNT_W(8), .MIN_EDGES(8), .MAX_EDGES(12), .GOOD_WIN(3)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ft_div_i(ftDiv), .clr_i(clr),
        .cnt_o(cnt), .cnt_vld_o(vld), .clk_ok_o(ok), .lost_o(lost)
    );

    ft_clk_mon #(
        .WIN_CYC(100), .CNT_W(4), .MIN_EDGES(8), .MAX_EDGES(12), .GOOD_WIN(3)
    ) dutSat (
        .clk_i(clk), .rst_n_i(rst_n), .ft_div_i(ftDiv), .clr_i(clr),
        .cnt_o(cntS), .cnt_vld_o(vldS), .clk_ok_o(okS), .lost_o(lostS)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Advance to the next falling edge and, if enabled, toggle the FT input every halfPer cycles.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ftRun) begin
            if (phase == 0) ftDiv = ~ftDiv;
            phase = (phase + 1 >= halfPer) ? 0 : phase + 1;
        end
    endtask

    // Step until the main instance pulses its valid strobe, bounded to 150 cycles.
    task automatic wait_vld();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 150 && !found; i++) begin
            prevOk   = ok;
            prevLost = lost;
            step();
            if (vld === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL vld_timeout: no cnt_vld_o pulse within 150 cycles (cyc=%0d)", cyc);
        end
    endtask

    // Release reset on a falling edge and restart the FT toggle pattern from a known phase.
    task automatic release_reset();
        step();
        rst_n   = 1'b1;
        cyc     = 0;
        phase   = 0;
        halfPer = 10;
        ftRun   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ftDiv = 1'b0;
        clr   = 1'b0;
        step();
        step();
        checks++; if (cnt !== 8'd0)  begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++; if (vld !== 1'b0)  begin errors++; $display("[TB] FAIL reset_vld: got %b expected 0", vld); end
        checks++; if (ok !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ok: got %b expected 0", ok); end
        checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost: got %b expected 0", lost); end
        checks++; if (cntS !== 4'd0) begin errors++; $display("[TB] FAIL reset_cntS: got %0d expected 0", cntS); end
        checks++; if (vldS !== 1'b0 || okS !== 1'b0 || lostS !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sat_flags: got vld=%b ok=%b lost=%b expected 0/0/0", vldS, okS, lostS);
        end
        release_reset();
    endtask

    task automatic test_steady();
        for (int p = 1; p <= 3; p++) begin
            wait_vld();
            checks++; if (cyc != 100 * p) begin errors++; $display("[TB] FAIL steady_time%0d: pulse at cycle %0d expected %0d", p, cyc, 100 * p); end
            checks++; if (cnt !== 8'd10) begin errors++; $display("[TB] FAIL steady_cnt%0d: got %0d expected 10", p, cnt); end
            checks++; if (ok !== (p == 3)) begin errors++; $display("[TB] FAIL steady_ok%0d: got %b expected %b", p, ok, (p == 3)); end
            checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL steady_lost%0d: got %b expected 0", p, lost); end
            if (p == 1) begin
                step();
                checks++; if (vld !== 1'b0) begin errors++; $display("[TB] FAIL vld_width: got %b expected 0 one cycle after pulse", vld); end
            end
        end
    endtask

    task automatic test_clock_stops();
        ftRun = 1'b0;
        wait_vld();
        checks++; if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL stop_cnt: got %0d expected 0", cnt); end
        checks++; if (prevOk !== 1'b1 || prevLost !== 1'b0) begin
            errors++; $display("[TB] FAIL stop_before: got ok=%b lost=%b expected ok=1 lost=0", prevOk, prevLost);
        end
        checks++; if (ok !== 1'b0 || lost !== 1'b1) begin
            errors++; $display("[TB] FAIL stop_edge: got ok=%b lost=%b expected ok=0 lost=1", ok, lost);
        end
        phase = 0;
        ftRun = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            wait_vld();
            checks++; if (cnt !== 8'd10) begin errors++; $display("[TB] FAIL recover_cnt%0d: got %0d expected 10", p, cnt); end
            checks++; if (ok !== (p == 3)) begin errors++; $display("[TB] FAIL recover_ok%0d: got %b expected %b", p, ok, (p == 3)); end
            checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL recover_lost%0d: got %b expected 1", p, lost); end
        end
    endtask

    task automatic test_clear_collision();
        step();
        checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL clr_before: got %b expected 1", lost); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL clr_plain: got %b expected 0", lost); end
        ftRun = 1'b0;
        for (int i = 0; i < 200 && cyc < 799; i++) step();
        checks++; if (lost !== 1'b0 || ok !== 1'b1) begin
            errors++; $display("[TB] FAIL clr_pre_collision: got ok=%b lost=%b expected ok=1 lost=0", ok, lost);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (vld !== 1'b1) begin errors++; $display("[TB] FAIL collision_vld: got %b expected 1", vld); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("[TB] FAIL collision_cnt: got %0d expected 1", cnt); end
        checks++; if (ok !== 1'b0 || lost !== 1'b1) begin
            errors++; $display("[TB] FAIL collision_set_wins: got ok=%b lost=%b expected ok=0 lost=1", ok, lost);
        end
        step();
        checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL collision_sticky: got %b expected 1", lost); end
    endtask

    task automatic test_out_of_range_high();
        halfPer = 4;
        phase   = 0;
        ftRun   = 1'b1;
        wait_vld();
        for (int p = 1; p <= 3; p++) begin
            wait_vld();
            checks++; if (cnt !== 8'd25) begin errors++; $display("[TB] FAIL high_cnt%0d: got %0d expected 25", p, cnt); end
            checks++; if (ok !== 1'b0) begin errors++; $display("[TB] FAIL high_ok%0d: got %b expected 0", p, ok); end
        end
    endtask

    task automatic test_saturation();
        halfPer = 3;
        phase   = 0;
        wait_vld();
        wait_vld();
        checks++; if (vldS !== 1'b1) begin errors++; $display("[TB] FAIL sat_vld: got %b expected 1", vldS); end
        checks++; if (cntS !== 4'd15) begin errors++; $display("[TB] FAIL sat_cnt: got %0d expected 15", cntS); end
        checks++; if (okS !== 1'b0) begin errors++; $display("[TB] FAIL sat_ok: got %b expected 0", okS); end
        checks++; if (cnt < 8'd33 || cnt > 8'd34) begin errors++; $display("[TB] FAIL sat_wide_cnt: got %0d expected 33..34", cnt); end
    endtask

    task automatic test_reset_mid_window();
        halfPer = 10;
        phase   = 0;
        for (int p = 0; p < 6 && ok !== 1'b1; p++) wait_vld();
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL midrst_reach_ok: got %b expected 1", ok); end
        for (int i = 0; i < 50; i++) step();
        rst_n = 1'b0;
        ftRun = 1'b0;
        ftDiv = 1'b0;
        #1;
        checks++; if (cnt !== 8'd0 || vld !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_cnt: got cnt=%0d vld=%b expected 0/0", cnt, vld);
        end
        checks++; if (ok !== 1'b0 || lost !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_flags: got ok=%b lost=%b expected 0/0", ok, lost);
        end
        step();
        step();
        release_reset();
        wait_vld();
        checks++; if (cyc != 100) begin errors++; $display("[TB] FAIL midrst_first_pulse: at cycle %0d expected 100", cyc); end
        checks++; if (cnt !== 8'd10 || ok !== 1'b0 || lost !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_first_window: got cnt=%0d ok=%b lost=%b expected 10/0/0", cnt, ok, lost);
        end
    endtask

    // Scenario sequence; each task leaves the DUT in the state the next one expects.
    initial begin
        test_reset();
        test_steady();
        test_clock_stops();
        test_clear_collision();
        test_out_of_range_high();
        test_saturation();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
